// File: rtl/datapath_mc.sv
// datapath_mc: parametrised multi-cycle CPU datapath with register file,
// Pc/Sp/Lr/Ir/AluOut, a flag-producing ALU and a muxed req/ack memory port.
// All architectural writes freeze while a memory access is outstanding.
// Optional feature macro: DP_FLAGS_REG_EN -- when defined, Flags is a register
// loaded together with AluOut; otherwise Flags follows the live ALU result.
module datapath_mc #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 8,
  parameter logic [WIDTH-1:0] SP_INIT = '1,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       alu_op,
  input  logic [1:0]       op1_sel,
  input  logic             op2_sel,
  input  logic [RW-1:0]    rs1,
  input  logic [RW-1:0]    rs2,
  input  logic [RW-1:0]    rw,
  input  logic [IMM_W-1:0] imm,
  input  logic             reg_we,
  input  logic             wd_sel,
  input  logic [1:0]       pc_sel,
  input  logic             pc_we,
  input  logic             sp_we,
  input  logic             lr_we,
  input  logic             alu_we,
  input  logic             ir_we,
  input  logic [1:0]       mem_op,
  input  logic             addr_sel,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic [WIDTH-1:0] ir,
  output logic [3:0]       flags
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] pc, sp, lr, aluout, memdata;
  logic [WIDTH-1:0] rd1, rd2, op1, op2, imm_ext;
  logic [WIDTH-1:0] alu_res, wdata, pc_in, pc_plus1;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  assign rd1      = regs[rs1];
  assign rd2      = regs[rs2];
  assign imm_ext  = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign op2      = op2_sel ? rd2 : imm_ext;
  assign pc_plus1 = pc + {{(WIDTH-1){1'b0}}, 1'b1};
  assign wdata    = wd_sel ? memdata : alu_res;
  assign busy     = (state == ACCESS);
  assign sum_ext  = {1'b0, op1} + {1'b0, op2};
  assign diff_ext = {1'b0, op1} - {1'b0, op2};

  // Select the first ALU operand from the register file or a special register
  always_comb begin
    op1 = rd1;
    case (op1_sel)
      2'd0:    op1 = rd1;
      2'd1:    op1 = pc;
      2'd2:    op1 = sp;
      default: op1 = lr;
    endcase
  end

  // Next-Pc source; Pc+1 naturally wraps from all-ones to zero
  always_comb begin
    pc_in = pc_plus1;
    case (pc_sel)
      2'd0:    pc_in = pc_plus1;
      2'd1:    pc_in = aluout;
      2'd2:    pc_in = lr;
      default: pc_in = memdata;
    endcase
  end

  // ALU result plus carry/overflow; SUB carry means "no borrow"
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      3'd1: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = ~diff_ext[WIDTH];
        alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      3'd2: alu_res = op1 & op2;
      3'd3: alu_res = op1 | op2;
      3'd4: alu_res = op1 ^ op2;
      3'd5: alu_res = op2;
      3'd6: begin
        alu_res = {op1[WIDTH-2:0], 1'b0};
        alu_c   = op1[WIDTH-1];
      end
      default: begin
        alu_res = {1'b0, op1[WIDTH-1:1]};
        alu_c   = op1[0];
      end
    endcase
  end

  assign alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};

`ifdef DP_FLAGS_REG_EN
  logic [3:0] flags_q;

  // Capture flags together with AluOut so they describe the stored result
  always_ff @(posedge clock) begin
    if (reset)
      flags_q <= '0;
    else if (alu_we && !busy)
      flags_q <= alu_flags;
  end

  assign flags = flags_q;
`else
  assign flags = alu_flags;
`endif

  // Memory sequencer: accept in IDLE, hold strobes in ACCESS until acknowledged
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      memdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op == 2'd1 || mem_op == 2'd2) begin
            mem_addr  <= addr_sel ? aluout : pc;
            mem_wdata <= rd2;
            mem_rd    <= (mem_op == 2'd1);
            mem_wr    <= (mem_op == 2'd2);
            state     <= ACCESS;
          end
        end
        default: begin
          if (mem_ack) begin
            if (mem_rd)
              memdata <= mem_rdata;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  // Architectural state; every enable is frozen while an access is outstanding
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pc     <= '0;
      sp     <= SP_INIT;
      lr     <= '0;
      ir     <= '0;
      aluout <= '0;
    end else if (!busy) begin
      if (reg_we) regs[rw] <= wdata;
      if (pc_we)  pc       <= pc_in;
      if (sp_we)  sp       <= alu_res;
      if (lr_we)  lr       <= pc;
      if (alu_we) aluout   <= alu_res;
      if (ir_we)  ir       <= memdata;
    end
  end

endmodule
